instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of `control_unit` in the multicycle accumulator processor. It owns the program counter, issues 16-bit instruction reads to memory over a ready-handshake, and latches the fetched word into the instruction register. It presents the 5-bit `Opcode` (instr[15:11]) and instruction metadata to `control_unit`. It accepts PC redirects for jumps and branches, including redirects that arrive while a fetch is still outstanding.

---
 rtl/instr_fetch_unit.sv | 90 +++++++++
 tb/tb_instr_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, memory read handshake and instruction register.
// Redirects during an outstanding read squash the returning word.
module instr_fetch_unit #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    PC_INC     = 2
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic                  fetch_req,
   input  logic                  PCWrite,
   input  logic [ADDR_WIDTH-1:0] pc_target,
   output logic                  mem_read,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ready,
   input  logic [15:0]           mem_rdata,
   output logic [15:0]           instr,
   output logic [4:0]            Opcode,
   output logic                  instr_valid,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic [ADDR_WIDTH-1:0] instr_pc_plus,
   output logic [15:0]           fetch_count
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      VALID
   } stateT;

   localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(PC_INC);

   stateT                 state;
   logic [ADDR_WIDTH-1:0] reqAddr;
   logic                  squash;

   assign mem_read      = (state == FETCH);
   assign mem_addr      = reqAddr;
   assign Opcode        = instr[15:11];
   assign instr_pc_plus = instr_pc + INC;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         reqAddr     <= RESET_PC;
         instr       <= '0;
         instr_pc    <= '0;
         squash      <= 1'b0;
         fetch_count <= '0;
         instr_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE, VALID: begin
               if (PCWrite)
                  pc <= pc_target;
               if (fetch_req) begin
                  reqAddr     <= PCWrite ? pc_target : pc;
                  state       <= FETCH;
                  instr_valid <= 1'b0;
               end
            end
            FETCH: begin
               if (mem_ready) begin
                  if (squash || PCWrite) begin
                     // drop the stale word and re-request at the newest PC
                     squash  <= 1'b0;
                     reqAddr <= PCWrite ? pc_target : pc;
                     if (PCWrite)
                        pc <= pc_target;
                  end else begin
                     instr       <= mem_rdata;
                     instr_pc    <= reqAddr;
                     pc          <= reqAddr + INC;
                     fetch_count <= fetch_count + 16'd1;
                     instr_valid <= 1'b1;
                     state       <= VALID;
                  end
               end else if (PCWrite) begin
                  pc     <= pc_target;
                  squash <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: fetches, wait states,
// redirects, squashes, PC wrap and reset during an outstanding read.
module tb_instr_fetch_unit;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        fetch_req;
   logic        PCWrite;
   logic [15:0] pc_target;
   logic        mem_read;
   logic [15:0] mem_addr;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic [15:0] instr;
   logic [4:0]  Opcode;
   logic        instr_valid;
   logic [15:0] pc;
   logic [15:0] instr_pc;
   logic [15:0] instr_pc_plus;
   logic [15:0] fetch_count;

   typedef struct packed {
      logic [15:0] data;
      logic [15:0] addr;
   } sbEntry;

   sbEntry      sbQ[$];
   int          nCompared = 0;
   int          nMismatched = 0;
   logic [15:0] expCount = 16'd0;
   logic [15:0] heldInstr;

   instr_fetch_unit #(
      .ADDR_WIDTH(16),
      .RESET_PC  (16'h0000),
      .PC_INC    (2)
   ) dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .fetch_req    (fetch_req),
      .PCWrite      (PCWrite),
      .pc_target    (pc_target),
      .mem_read     (mem_read),
      .mem_addr     (mem_addr),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .instr        (instr),
      .Opcode       (Opcode),
      .instr_valid  (instr_valid),
      .pc           (pc),
      .instr_pc     (instr_pc),
      .instr_pc_plus(instr_pc_plus),
      .fetch_count  (fetch_count)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] memWord(input logic [15:0] a);
      return (a * 16'd3) ^ 16'h5A3C;
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic pcw, input logic [15:0] tgt);
      fetch_req = 1'b1;
      PCWrite   = pcw;
      pc_target = tgt;
      tick();
      fetch_req = 1'b0;
      PCWrite   = 1'b0;
      checkVal("issueRd", mem_read, 1);
      checkVal("issueVld", instr_valid, 0);
   endtask

   task automatic popCheck();
      sbEntry      e;
      logic [15:0] nxt;
      if (sbQ.size() == 0) begin
         checkVal("sbUnderflow", 1, 0);
         return;
      end
      e        = sbQ.pop_front();
      nxt      = e.addr + 16'd2;
      expCount = expCount + 16'd1;
      checkVal("instr", instr, e.data);
      checkVal("opcode", Opcode, e.data[15:11]);
      checkVal("instrPc", instr_pc, e.addr);
      checkVal("pc", pc, nxt);
      checkVal("pcPlus", instr_pc_plus, nxt);
      checkVal("valid", instr_valid, 1);
      checkVal("count", fetch_count, expCount);
      checkVal("rdDone", mem_read, 0);
   endtask

   task automatic complete(input int waits, input logic [15:0] expAddr);
      sbQ.push_back('{data: memWord(expAddr), addr: expAddr});
      for (int i = 0; i < waits; i++) begin
         checkVal("waitRd", mem_read, 1);
         checkVal("waitAddr", mem_addr, expAddr);
         checkVal("waitVld", instr_valid, 0);
         tick();
      end
      checkVal("reqRd", mem_read, 1);
      checkVal("reqAddr", mem_addr, expAddr);
      mem_ready = 1'b1;
      mem_rdata = memWord(mem_addr);
      tick();
      mem_ready = 1'b0;
      mem_rdata = 16'h0000;
      popCheck();
   endtask

   initial begin
      Reset     = 1'b0;
      fetch_req = 1'b0;
      PCWrite   = 1'b0;
      pc_target = 16'h0000;
      mem_ready = 1'b0;
      mem_rdata = 16'h0000;
      tick();
      tick();
      checkVal("rstRd", mem_read, 0);
      checkVal("rstPc", pc, 16'h0000);
      checkVal("rstAddr", mem_addr, 16'h0000);
      checkVal("rstInstr", instr, 16'h0000);
      checkVal("rstOp", Opcode, 5'h00);
      checkVal("rstVld", instr_valid, 0);
      checkVal("rstCnt", fetch_count, 16'h0000);
      Reset = 1'b1;
      tick();

      // zero-wait fetch at 0x0000
      issue(1'b0, 16'h0000);
      complete(0, 16'h0000);
      checkVal("t1Instr", instr, 16'h5A3C);
      checkVal("t1Op", Opcode, 5'h0B);

      // VALID holds the word without fetch_req
      tick();
      tick();
      checkVal("holdInstr", instr, 16'h5A3C);
      checkVal("holdVld", instr_valid, 1);

      // three wait states at 0x0002
      issue(1'b0, 16'h0000);
      complete(3, 16'h0002);

      // redirect in wait cycle 2 of fetch to 0x0004
      heldInstr = instr;
      issue(1'b0, 16'h0000);
      checkVal("sqAddr0", mem_addr, 16'h0004);
      tick();
      PCWrite   = 1'b1;
      pc_target = 16'h0100;
      tick();
      PCWrite = 1'b0;
      checkVal("sqAddrStable", mem_addr, 16'h0004);
      checkVal("sqPc", pc, 16'h0100);
      tick();
      mem_ready = 1'b1;
      mem_rdata = memWord(16'h0004);
      tick();
      mem_ready = 1'b0;
      checkVal("sqReRd", mem_read, 1);
      checkVal("sqInstr", instr, heldInstr);
      checkVal("sqCnt", fetch_count, expCount);
      complete(0, 16'h0100);

      // fetch_req with redirect in the same cycle
      heldInstr = instr;
      issue(1'b1, 16'h0040);
      checkVal("jmpAddr", mem_addr, 16'h0040);
      checkVal("jmpInstrKept", instr, heldInstr);
      complete(1, 16'h0040);

      // mem_ready outside FETCH is ignored
      heldInstr = instr;
      mem_ready = 1'b1;
      mem_rdata = 16'hFFFF;
      tick();
      mem_ready = 1'b0;
      checkVal("strayInstr", instr, heldInstr);
      checkVal("strayCnt", fetch_count, expCount);
      checkVal("strayVld", instr_valid, 1);

      // redirect in VALID, then fetch at the top of memory
      PCWrite   = 1'b1;
      pc_target = 16'hFFFE;
      tick();
      PCWrite = 1'b0;
      checkVal("vRedirPc", pc, 16'hFFFE);
      checkVal("vRedirInstr", instr, heldInstr);
      checkVal("vRedirVld", instr_valid, 1);
      issue(1'b0, 16'h0000);
      complete(0, 16'hFFFE);
      checkVal("wrapPc", pc, 16'h0000);
      checkVal("wrapPlus", instr_pc_plus, 16'h0000);

      // redirect coincident with mem_ready squashes immediately
      heldInstr = instr;
      issue(1'b0, 16'h0000);
      PCWrite   = 1'b1;
      pc_target = 16'h0200;
      mem_ready = 1'b1;
      mem_rdata = memWord(16'h0000);
      tick();
      PCWrite   = 1'b0;
      mem_ready = 1'b0;
      checkVal("coPc", pc, 16'h0200);
      checkVal("coInstr", instr, heldInstr);
      complete(0, 16'h0200);

      // two redirects during one fetch: last wins, single squash
      issue(1'b0, 16'h0000);
      PCWrite   = 1'b1;
      pc_target = 16'h0300;
      tick();
      pc_target = 16'h0380;
      tick();
      PCWrite   = 1'b0;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      complete(0, 16'h0380);

      // reset during an outstanding fetch
      issue(1'b0, 16'h0000);
      #2;
      Reset = 1'b0;
      #1;
      checkVal("arRd", mem_read, 0);
      checkVal("arVld", instr_valid, 0);
      checkVal("arInstr", instr, 16'h0000);
      checkVal("arPc", pc, 16'h0000);
      checkVal("arCnt", fetch_count, 16'h0000);
      expCount  = 16'd0;
      mem_ready = 1'b1;
      mem_rdata = 16'hBEEF;
      tick();
      Reset = 1'b1;
      tick();
      tick();
      mem_ready = 1'b0;
      checkVal("lateRd", mem_read, 0);
      checkVal("lateVld", instr_valid, 0);
      checkVal("lateInstr", instr, 16'h0000);
      checkVal("lateCnt", fetch_count, 16'h0000);

      // normal operation resumes from the reset PC
      issue(1'b0, 16'h0000);
      complete(2, 16'h0000);

      checkVal("sbEmpty", sbQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               nCompared, nMismatched);
      $finish;
   end

endmodule
